// File: rtl/int_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_accum_pkg
// Description : Shared widths, opcode/format encodings and result record for
//               the integer accumulator stage.
// Revision    : 1.0 - initial release
// ============================================================================
package int_accum_pkg;

  localparam int XLEN = 32;

  // Operation encodings carried on in_op.
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Operand formats carried on in_fmt; 2'b11 behaves as W32.
  localparam logic [1:0] FMT_U16 = 2'b00;
  localparam logic [1:0] FMT_S16 = 2'b01;
  localparam logic [1:0] FMT_W32 = 2'b10;

  // One buffered output: accumulator value after the op plus overflow flag.
  typedef struct packed {
    logic [XLEN-1:0] value;
    logic            ovf;
  } result_t;

endpackage : int_accum_pkg
`default_nettype wire

// File: rtl/int_accum_fifo.sv
`default_nettype none
// ============================================================================
// Module      : int_accum_fifo
// Description : Show-ahead result FIFO. The head entry is presented on
//               o_data whenever non-empty and forced to zero when empty.
//               Pops on empty are ignored; push+pop when full is allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module int_accum_fifo
  import int_accum_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  result_t                      i_data,
  input  logic                         i_pop,
  output result_t                      o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  result_t       r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A push into a full buffer is only accepted when a pop frees the slot.
  assign w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping with wrap at DEPTH (any depth, not just 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

endmodule : int_accum_fifo
`default_nettype wire

// File: rtl/int_accum.sv
`default_nettype none
// ============================================================================
// Module      : int_accum
// Description : Two-stage 32-bit integer accumulator. Stage 1 registers the
//               zero/sign-extended operand; stage 2 applies LOAD/ADD/SUB/CLEAR
//               to the accumulator and pushes {result, overflow} into a
//               credit-controlled show-ahead output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module int_accum
  import int_accum_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [1:0]      in_fmt,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_ovf,
  output logic [XLEN-1:0] acc
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW:0] c_DEPTH = (CW+1)'(OUT_DEPTH);

  logic [XLEN-1:0] w_opnd;
  logic            w_accept;

  logic            r_s1_valid;
  logic [1:0]      r_s1_op;
  logic [XLEN-1:0] r_s1_opnd;

  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_new;
  logic            w_ovf;

  result_t         w_push_data;
  result_t         w_head;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credits;

  assign w_accept = in_valid && in_ready;

  // Operand extension to integer width; unknown format 2'b11 acts as W32.
  always_comb begin
    w_opnd = in_data;
    case (in_fmt)
      FMT_U16: w_opnd = {{(XLEN-16){1'b0}}, in_data[15:0]};
      FMT_S16: w_opnd = {{(XLEN-16){in_data[15]}}, in_data[15:0]};
      default: w_opnd = in_data;
    endcase
  end

  // Stage 1: capture the accepted operation and its extended operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_LOAD;
      r_s1_opnd  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op   <= in_op;
        r_s1_opnd <= w_opnd;
      end
    end
  end

  assign w_sum  = r_acc + r_s1_opnd;
  assign w_diff = r_acc - r_s1_opnd;

  // Stage 2 execute: new accumulator value and signed-overflow detection.
  always_comb begin
    w_new = r_acc;
    w_ovf = 1'b0;
    case (r_s1_op)
      OP_LOAD: begin
        w_new = r_s1_opnd;
      end
      OP_ADD: begin
        w_new = w_sum;
        w_ovf = (r_acc[XLEN-1] == r_s1_opnd[XLEN-1]) &&
                (w_sum[XLEN-1] != r_acc[XLEN-1]);
      end
      OP_SUB: begin
        w_new = w_diff;
        w_ovf = (r_acc[XLEN-1] != r_s1_opnd[XLEN-1]) &&
                (w_diff[XLEN-1] != r_acc[XLEN-1]);
      end
      default: begin
        w_new = '0;
      end
    endcase
  end

  // Architectural accumulator: reads its own current value, so dependent
  // back-to-back operations need no forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (r_s1_valid) begin
      r_acc <= w_new;
    end
  end

  assign w_push_data.value = w_new;
  assign w_push_data.ovf   = w_ovf;

  int_accum_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s1_valid),
    .i_data  (w_push_data),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // Credit check: the op in stage 1 has a reserved slot, so stage 2 never
  // stalls. Uses registered state only, so out_ready has no path to in_ready.
  assign w_credits = {1'b0, w_count} + {{CW{1'b0}}, r_s1_valid};
  assign in_ready  = (w_credits < c_DEPTH);

  assign out_valid  = (w_count != '0);
  assign out_result = w_head.value;
  assign out_ovf    = w_head.ovf;
  assign acc        = r_acc;

endmodule : int_accum
`default_nettype wire
